sd_stream_reader: RTL

//  Streaming client on one SD mutex port: requests the card, reads consecutive 512-byte blocks

---
 rtl/sd_stream_pkg.sv | 21 ++
 rtl/sd_pingpong_ram.sv | 26 ++
 rtl/sd_stream_reader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sd_stream_pkg.sv
// Shared sizes and fill-FSM encoding for the SD stream reader slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sd_stream_pkg;
  localparam int BLOCK_BYTES     = 512;
  localparam int WORDS_PER_BLOCK = 128;
  // Byte address spans both ping-pong halves; word address likewise
  localparam int BYTE_AW = $clog2(2 * BLOCK_BYTES);
  localparam int WORD_AW = $clog2(2 * WORDS_PER_BLOCK);

  // S_HOLD is the post-DONE wait for the next fill half to drain
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_HOLD,
    S_ERROR
  } fill_state_e;
endpackage

// File: rtl/sd_pingpong_ram.sv
// Two-half sample buffer: byte-wide write port from the SD card, word-wide read port.
// Latency: read data registered, valid 1 cycle after i_re.
// Backpressure: read register holds its word while i_re is low.
module sd_pingpong_ram
  import sd_stream_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [BYTE_AW-1:0] i_waddr,
  input  logic [7:0]         i_wdata,
  input  logic               i_re,
  input  logic [WORD_AW-1:0] i_raddr,
  output logic [31:0]        o_rdata
);
  logic [31:0] r_mem [2**WORD_AW];

  // Byte lane write: low address bits pick the lane, so byte 4k lands in [7:0]
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr[BYTE_AW-1:2]][{i_waddr[1:0], 3'b000} +: 8] <= i_wdata;
  end

  // Registered read port, held while not enabled
  always_ff @(posedge i_clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/sd_stream_reader.sv
// SD mutex client: reads consecutive blocks into a ping-pong RAM and streams 32-bit stereo words.
// Latency: first o_sample_valid 2 cycles after DONE of the first block; then 1 word/cycle.
// Backpressure: o_sample_valid/i_sample_ready; no new block is requested until a half is empty.
module sd_stream_reader
  import sd_stream_pkg::*;
#(
  parameter int unsigned LOOP_BLOCKS = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [31:0] i_start_block,
  output logic        o_request,
  input  logic        i_grant,
  output logic [31:0] o_block,
  output logic        o_read,
  input  logic        i_busy,
  input  logic        i_card_error,
  input  logic [8:0]  i_address,
  input  logic [7:0]  i_data,
  input  logic        i_write_enable,
  output logic [31:0] o_sample,
  output logic        o_sample_valid,
  input  logic        i_sample_ready,
  output logic        o_active,
  output logic        o_underrun,
  output logic        o_error
);
  fill_state_e        r_state, w_state_nxt;
  logic [31:0]        r_block, r_start_blk, r_blk_cnt;
  logic [1:0]         r_full, w_full_nxt;
  logic               r_fill, r_stop_pend, r_vld, r_underrun, r_error;
  logic [WORD_AW-1:0] r_rd_ptr;   // word being presented: {half, index}
  logic [WORD_AW-1:0] r_iss_ptr;  // next word to fetch from the RAM
  logic               w_start, w_done, w_xfer, w_retire, w_issue, w_we;
  logic [31:0]        w_rdata;

  assign w_start        = i_start && (r_state == S_IDLE) && !i_card_error;
  assign w_done         = (r_state == S_DONE);
  assign w_we           = i_write_enable && i_grant && (r_state == S_WAIT);
  assign o_sample_valid = r_vld && (r_state != S_ERROR);
  assign o_sample       = o_sample_valid ? w_rdata : 32'd0;
  assign w_xfer         = o_sample_valid && i_sample_ready;
  assign w_retire       = w_xfer && (r_rd_ptr[WORD_AW-2:0] == 7'(WORDS_PER_BLOCK - 1));
  // Prefetch whenever the output slot is free or being emptied this cycle
  assign w_issue        = r_full[r_iss_ptr[WORD_AW-1]] && (!r_vld || w_xfer) &&
                          (r_state != S_ERROR) && !w_start;
  assign o_block        = r_block;
  assign o_underrun     = r_underrun;
  assign o_error        = r_error;

  // Half occupancy after this cycle: a drain release and a fill completion may coincide
  always_comb begin
    w_full_nxt = r_full;
    if (w_retire) w_full_nxt[r_rd_ptr[WORD_AW-1]] = 1'b0;
    if (w_done)   w_full_nxt[r_fill] = 1'b1;
  end

  // Fill FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Fill FSM next state; a card error overrides everything
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_REQ;
      S_REQ:   if (i_stop) w_state_nxt = S_IDLE;
               else if (i_grant) w_state_nxt = S_ISSUE;
      S_ISSUE: if (i_busy) w_state_nxt = S_WAIT;
      S_WAIT:  if (!i_busy) w_state_nxt = S_DONE;
      S_DONE:  if (r_stop_pend || i_stop) w_state_nxt = S_IDLE;
               else if (!w_full_nxt[!r_fill]) w_state_nxt = S_REQ;
               else w_state_nxt = S_HOLD;
      S_HOLD:  if (i_stop) w_state_nxt = S_IDLE;
               else if (!r_full[r_fill]) w_state_nxt = S_REQ;
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_card_error) w_state_nxt = S_ERROR;
  end

  // Fill FSM outputs; DONE and HOLD drop Request so the arbiter can rotate
  always_comb begin
    o_request = 1'b0;
    o_read    = 1'b0;
    o_active  = 1'b0;
    case (r_state)
      S_REQ, S_WAIT:  begin o_request = 1'b1; o_active = 1'b1; end
      S_ISSUE:        begin o_request = 1'b1; o_read = 1'b1; o_active = 1'b1; end
      S_DONE, S_HOLD: o_active = 1'b1;
      default:        ;
    endcase
  end

  // Block address: latched on Start, advanced (or looped) once per completed block
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_block     <= 32'd0;
      r_start_blk <= 32'd0;
      r_blk_cnt   <= 32'd0;
    end else if (w_start) begin
      r_block     <= i_start_block;
      r_start_blk <= i_start_block;
      r_blk_cnt   <= 32'd0;
    end else if (w_done) begin
      if ((LOOP_BLOCKS != 0) && (r_blk_cnt == LOOP_BLOCKS - 1)) begin
        r_block   <= r_start_blk;
        r_blk_cnt <= 32'd0;
      end else begin
        r_block   <= r_block + 32'd1;
        r_blk_cnt <= r_blk_cnt + 32'd1;
      end
    end
  end

  // Buffer bookkeeping: half flags, fill/read pointers, output slot, pending stop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full      <= 2'b00;
      r_fill      <= 1'b0;
      r_rd_ptr    <= '0;
      r_iss_ptr   <= '0;
      r_vld       <= 1'b0;
      r_stop_pend <= 1'b0;
    end else if (w_start) begin
      r_full      <= 2'b00;
      r_fill      <= 1'b0;
      r_rd_ptr    <= '0;
      r_iss_ptr   <= '0;
      r_vld       <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_done)  r_fill <= !r_fill;
      if (w_xfer)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_issue) r_iss_ptr <= r_iss_ptr + 1'b1;
      if (w_issue)     r_vld <= 1'b1;
      else if (w_xfer) r_vld <= 1'b0;
      if (i_stop && ((r_state == S_ISSUE) || (r_state == S_WAIT))) r_stop_pend <= 1'b1;
    end
  end

  // Sticky status flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_underrun <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (i_card_error) r_error <= 1'b1;
      if (w_start) r_underrun <= 1'b0;
      else if (o_active && i_sample_ready && !o_sample_valid) r_underrun <= 1'b1;
    end
  end

  sd_pingpong_ram u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr ({r_fill, i_address}),
    .i_wdata (i_data),
    .i_re    (w_issue),
    .i_raddr (r_iss_ptr),
    .o_rdata (w_rdata)
  );
endmodule
